// File: rtl/uart_rx_pkg.sv
// Package for the UART RX frame checker.
// Holds the frame FSM state encoding and the helper that sizes the
// runtime data-length field from the maximum data width.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } state_t;

  // Width needed to hold any length 0..data_w.
  function automatic int calc_len_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/uart_rx_frame_checker_if.sv
// Sample / result bundle between the RX sampler, the frame checker and its consumers.
//   master : sampler side, drives frame_start/sample_valid/sampled_bit, sees results
//   slave  : frame checker, consumes samples, drives busy/rx_data/rx_valid/error pulses
// Handshake: there is no backpressure. frame_start and sample_valid are single-cycle
// qualifiers that the slave must accept on the cycle they are high; rx_valid and the
// error flags are single-cycle pulses that the consumer must capture on that cycle.
interface uart_rx_frame_checker_if #(
  parameter int DATA_W = 8
);
  logic              frame_start;
  logic              sample_valid;
  logic              sampled_bit;
  logic              busy;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              start_bit_error;
  logic              parity_error;
  logic              frame_error;
  logic              break_detect;

  modport master (
    output frame_start, sample_valid, sampled_bit,
    input  busy, rx_data, rx_valid, start_bit_error, parity_error, frame_error, break_detect
  );

  modport slave (
    input  frame_start, sample_valid, sampled_bit,
    output busy, rx_data, rx_valid, start_bit_error, parity_error, frame_error, break_detect
  );
endinterface

// File: rtl/uart_sat_counter.sv
// Saturating up-counter for error statistics.
//   clk, reset : clock, synchronous active-high reset
//   clr        : synchronous clear, wins over inc
//   inc        : count one event, holds at all-ones
//   count      : current value
module uart_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_frame_checker.sv
// UART RX frame validator. Consumes one mid-bit sample per sample_valid, checks the
// start, data, parity and stop fields and reports the assembled word plus per-frame
// error pulses one UCLK after the final sample.
// Ports:
//   UCLK, reset          : clock, synchronous active-high reset
//   rx_if (slave)        : samples in, word/valid/error pulses/busy out
//   cfg_data_len         : data bits per frame (0 or >DATA_W selects DATA_W)
//   cfg_parity_en/odd    : parity present / odd parity
//   cfg_stop2            : two stop bits
//   dbg_state            : current FSM state
// Optional feature, macro UART_RX_ERR_CNT_EN: adds err_cnt_clr and four saturating
// CNT_W-bit error counters (start, parity, frame, break).
module uart_rx_frame_checker
  import uart_rx_pkg::*;
#(
  parameter int DATA_W = 8
`ifdef UART_RX_ERR_CNT_EN
  , parameter int CNT_W = 8
`endif
  , localparam int LEN_W = calc_len_w(DATA_W)
) (
  input  logic                    UCLK,
  input  logic                    reset,
  uart_rx_frame_checker_if.slave  rx_if,
  input  logic [LEN_W-1:0]        cfg_data_len,
  input  logic                    cfg_parity_en,
  input  logic                    cfg_parity_odd,
  input  logic                    cfg_stop2,
  output state_t                  dbg_state
`ifdef UART_RX_ERR_CNT_EN
  , input  logic                  err_cnt_clr
  , output logic [CNT_W-1:0]      err_cnt_start
  , output logic [CNT_W-1:0]      err_cnt_parity
  , output logic [CNT_W-1:0]      err_cnt_frame
  , output logic [CNT_W-1:0]      err_cnt_break
`endif
);

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, eff_len;
  logic              par_en_q, par_odd_q, stop2_q;
  logic [DATA_W-1:0] data_q, data_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              all_zero_q, all_zero_d;
  logic              stop_fail_q, stop_fail_d;
  logic              par_fail_q, par_fail_d;
  logic              done, start_err;

  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q, start_err_q, parity_err_q, frame_err_q, break_q;

  wire sv  = rx_if.sample_valid;
  wire bit_in = rx_if.sampled_bit;

  // Out-of-range lengths fall back to the full word.
  assign eff_len = ((cfg_data_len == '0) || (cfg_data_len > LEN_W'(DATA_W)))
                   ? LEN_W'(DATA_W) : cfg_data_len;

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    all_zero_d  = all_zero_q;
    stop_fail_d = stop_fail_q;
    par_fail_d  = par_fail_q;
    done        = 1'b0;
    start_err   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Samples arriving while idle (including with frame_start) are dropped.
        if (rx_if.frame_start) begin
          state_d     = START;
          data_d      = '0;
          cnt_d       = '0;
          all_zero_d  = 1'b1;
          stop_fail_d = 1'b0;
          par_fail_d  = 1'b0;
        end
      end
      START: begin
        if (sv) begin
          if (bit_in) begin
            start_err = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (sv) begin
          for (int i = 0; i < DATA_W; i++) begin
            if (LEN_W'(i) == cnt_q) data_d[i] = bit_in;
          end
          cnt_d      = cnt_q + 1'b1;
          all_zero_d = all_zero_q & ~bit_in;
          if (cnt_q == len_q - 1'b1) state_d = par_en_q ? PARITY : STOP1;
        end
      end
      PARITY: begin
        if (sv) begin
          // Unused MSBs of data_q are zero, so a full-width XOR is safe.
          par_fail_d = (((^data_q) ^ bit_in) != par_odd_q);
          all_zero_d = all_zero_q & ~bit_in;
          state_d    = STOP1;
        end
      end
      STOP1: begin
        if (sv) begin
          stop_fail_d = stop_fail_q | ~bit_in;
          all_zero_d  = all_zero_q & ~bit_in;
          if (stop2_q) begin
            state_d = STOP2;
          end else begin
            state_d = IDLE;
            done    = 1'b1;
          end
        end
      end
      STOP2: begin
        if (sv) begin
          stop_fail_d = stop_fail_q | ~bit_in;
          all_zero_d  = all_zero_q & ~bit_in;
          state_d     = IDLE;
          done        = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge UCLK) begin
    if (reset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      stop2_q      <= 1'b0;
      data_q       <= '0;
      cnt_q        <= '0;
      all_zero_q   <= 1'b0;
      stop_fail_q  <= 1'b0;
      par_fail_q   <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      start_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      break_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      all_zero_q  <= all_zero_d;
      stop_fail_q <= stop_fail_d;
      par_fail_q  <= par_fail_d;
      // Configuration is frozen for the whole frame at its start.
      if ((state_q == IDLE) && rx_if.frame_start) begin
        len_q     <= eff_len;
        par_en_q  <= cfg_parity_en;
        par_odd_q <= cfg_parity_odd;
        stop2_q   <= cfg_stop2;
      end
      rx_valid_q   <= done;
      start_err_q  <= start_err;
      parity_err_q <= done & par_fail_d;
      // A break (all-zero frame) is reported instead of a framing error.
      frame_err_q  <= done & stop_fail_d & ~all_zero_d;
      break_q      <= done & all_zero_d;
      if (done) rx_data_q <= data_d;
    end
  end

  assign rx_if.busy            = (state_q != IDLE);
  assign rx_if.rx_data         = rx_data_q;
  assign rx_if.rx_valid        = rx_valid_q;
  assign rx_if.start_bit_error = start_err_q;
  assign rx_if.parity_error    = parity_err_q;
  assign rx_if.frame_error     = frame_err_q;
  assign rx_if.break_detect    = break_q;
  assign dbg_state             = state_q;

`ifdef UART_RX_ERR_CNT_EN
  uart_sat_counter #(.CNT_W(CNT_W)) u_cnt_start (
    .clk(UCLK), .reset(reset), .clr(err_cnt_clr), .inc(start_err_q), .count(err_cnt_start)
  );
  uart_sat_counter #(.CNT_W(CNT_W)) u_cnt_parity (
    .clk(UCLK), .reset(reset), .clr(err_cnt_clr), .inc(parity_err_q), .count(err_cnt_parity)
  );
  uart_sat_counter #(.CNT_W(CNT_W)) u_cnt_frame (
    .clk(UCLK), .reset(reset), .clr(err_cnt_clr), .inc(frame_err_q), .count(err_cnt_frame)
  );
  uart_sat_counter #(.CNT_W(CNT_W)) u_cnt_break (
    .clk(UCLK), .reset(reset), .clr(err_cnt_clr), .inc(break_q), .count(err_cnt_break)
  );
`endif

endmodule

// File: tb/tb_uart_rx_frame_checker.sv
// Directed bench for uart_rx_frame_checker (DATA_W=8; CNT_W=2 when UART_RX_ERR_CNT_EN).
module tb_uart_rx_frame_checker;
  import uart_rx_pkg::*;

  // ---------------- clock / reset ----------------
  logic UCLK = 1'b0;
  logic reset;
  always #5 UCLK = ~UCLK;

  uart_rx_frame_checker_if #(.DATA_W(8)) rx_if ();
  logic [3:0] cfg_data_len;
  logic       cfg_parity_en, cfg_parity_odd, cfg_stop2;
  state_t     dbg_state;
`ifdef UART_RX_ERR_CNT_EN
  logic       err_cnt_clr;
  logic [1:0] err_cnt_start, err_cnt_parity, err_cnt_frame, err_cnt_break;
`endif

  uart_rx_frame_checker #(
    .DATA_W(8)
`ifdef UART_RX_ERR_CNT_EN
    , .CNT_W(2)
`endif
  ) dut (
    .UCLK           (UCLK),
    .reset          (reset),
    .rx_if          (rx_if),
    .cfg_data_len   (cfg_data_len),
    .cfg_parity_en  (cfg_parity_en),
    .cfg_parity_odd (cfg_parity_odd),
    .cfg_stop2      (cfg_stop2),
    .dbg_state      (dbg_state)
`ifdef UART_RX_ERR_CNT_EN
    , .err_cnt_clr    (err_cnt_clr)
    , .err_cnt_start  (err_cnt_start)
    , .err_cnt_parity (err_cnt_parity)
    , .err_cnt_frame  (err_cnt_frame)
    , .err_cnt_break  (err_cnt_break)
`endif
  );

  // ---------------- scoreboard ----------------
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Every rx_valid must match the next expected word.
  always @(negedge UCLK) begin
    if (rx_if.rx_valid === 1'b1) begin
      if (exp_q.size() == 0) check("rx_unexpected", 32'(rx_if.rx_valid), 32'd0);
      else check("rx_data", 32'(rx_if.rx_data), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge UCLK);
    #1;
  endtask

  task automatic set_cfg(input logic [3:0] len, input logic pen, input logic podd, input logic s2);
    cfg_data_len   = len;
    cfg_parity_en  = pen;
    cfg_parity_odd = podd;
    cfg_stop2      = s2;
  endtask

  task automatic send_bit(input logic b);
    rx_if.sample_valid = 1'b1;
    rx_if.sampled_bit  = b;
    step();
    rx_if.sample_valid = 1'b0;
  endtask

  task automatic pulse_start();
    rx_if.frame_start = 1'b1;
    step();
    rx_if.frame_start = 1'b0;
  endtask

  // Full frame with a gap cycle between samples; returns right after the last sample edge.
  task automatic send_frame(input logic [7:0] data, input int len, input logic par_en,
                            input logic par_bit, input logic stop1, input logic has_stop2,
                            input logic stop2b);
    pulse_start();
    send_bit(1'b0);
    step();
    for (int i = 0; i < len; i++) begin
      send_bit(data[i]);
      step();
    end
    if (par_en) begin
      send_bit(par_bit);
      step();
    end
    if (has_stop2) begin
      send_bit(stop1);
      step();
      send_bit(stop2b);
    end else begin
      send_bit(stop1);
    end
  endtask

  // Called one cycle after the final sample: results present now, gone next cycle.
  task automatic expect_frame(input string tag, input logic par, input logic frm, input logic brk);
    check({tag, "_rx_valid"}, 32'(rx_if.rx_valid), 32'd1);
    check({tag, "_parity_error"}, 32'(rx_if.parity_error), 32'(par));
    check({tag, "_frame_error"}, 32'(rx_if.frame_error), 32'(frm));
    check({tag, "_break_detect"}, 32'(rx_if.break_detect), 32'(brk));
    check({tag, "_start_err"}, 32'(rx_if.start_bit_error), 32'd0);
    check({tag, "_busy"}, 32'(rx_if.busy), 32'd0);
    step();
    check({tag, "_valid_pulse"}, 32'(rx_if.rx_valid), 32'd0);
    check({tag, "_perr_pulse"}, 32'(rx_if.parity_error), 32'd0);
    check({tag, "_ferr_pulse"}, 32'(rx_if.frame_error), 32'd0);
    check({tag, "_brk_pulse"}, 32'(rx_if.break_detect), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    reset              = 1'b1;
    rx_if.frame_start  = 1'b0;
    rx_if.sample_valid = 1'b0;
    rx_if.sampled_bit  = 1'b1;
    set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
`ifdef UART_RX_ERR_CNT_EN
    err_cnt_clr = 1'b0;
`endif
    step(); step(); step();
    check("rst_busy", 32'(rx_if.busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_rx_valid", 32'(rx_if.rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_if.rx_data), 32'd0);
    check("rst_errors", 32'({rx_if.start_bit_error, rx_if.parity_error,
                              rx_if.frame_error, rx_if.break_detect}), 32'd0);
    reset = 1'b0;
    step();

    // 1: 8N1 0xA5
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_frame("t1", 1'b0, 1'b0, 1'b0);
    check("t1_hold", 32'(rx_if.rx_data), 32'hA5);

    // 2: false start, then a good frame
    pulse_start();
    check("t2_busy_start", 32'(rx_if.busy), 32'd1);
    check("t2_state_start", 32'(dbg_state), 32'(START));
    send_bit(1'b1);
    check("t2_start_err", 32'(rx_if.start_bit_error), 32'd1);
    check("t2_busy_drop", 32'(rx_if.busy), 32'd0);
    check("t2_no_valid", 32'(rx_if.rx_valid), 32'd0);
    step();
    check("t2_start_pulse", 32'(rx_if.start_bit_error), 32'd0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_frame("t2b", 1'b0, 1'b0, 1'b0);

    // 3: 7E1 0x35 wrong parity, then 7O1 0x35 correct parity
    set_cfg(4'd7, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(8'h35);
    send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_frame("t3_even", 1'b1, 1'b0, 1'b0);
    set_cfg(4'd7, 1'b1, 1'b1, 1'b0);
    exp_q.push_back(8'h35);
    send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_frame("t3_odd", 1'b0, 1'b0, 1'b0);

    // 4: 8N2 bad second stop; all-zero 8N1 break; all-zero 8O1 break with parity error
    set_cfg(4'd8, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    expect_frame("t4_stop2", 1'b0, 1'b1, 1'b0);
    set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(8'h00);
    send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_frame("t4_break", 1'b0, 1'b0, 1'b1);
    set_cfg(4'd8, 1'b1, 1'b1, 1'b0);
    exp_q.push_back(8'h00);
    send_frame(8'h00, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_frame("t4_brk_par", 1'b1, 1'b0, 1'b1);

    // Length 0 and out-of-range length both mean 8 bits
    set_cfg(4'd0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_frame("len0", 1'b0, 1'b0, 1'b0);
    set_cfg(4'd15, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(8'h96);
    send_frame(8'h96, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_frame("len15", 1'b0, 1'b0, 1'b0);

    // 5: cfg change + stray frame_start mid-DATA, frame uses latched 8N1
    set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(8'hC3);
    pulse_start();
    send_bit(1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      send_bit(i < 2);
      step();
    end
    set_cfg(4'd5, 1'b1, 1'b1, 1'b1);
    pulse_start();
    check("t5_state_data", 32'(dbg_state), 32'(DATA));
    check("t5_busy", 32'(rx_if.busy), 32'd1);
    for (int i = 3; i < 8; i++) begin
      send_bit(i >= 6);
      step();
    end
    check("t5_state_stop1", 32'(dbg_state), 32'(STOP1));
    send_bit(1'b1);
    expect_frame("t5_latched", 1'b0, 1'b0, 1'b0);

    // Reset while in STOP1 discards the frame
    set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
    send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t5_premature_valid", 32'(rx_if.rx_valid), 32'd1);
    exp_q.push_back(8'hFF);
    step();
    pulse_start();
    send_bit(1'b0);
    step();
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1);
      step();
    end
    check("t5_rst_at_stop1", 32'(dbg_state), 32'(STOP1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_rst_state", 32'(dbg_state), 32'(IDLE));
    check("t5_rst_busy", 32'(rx_if.busy), 32'd0);
    check("t5_rst_data", 32'(rx_if.rx_data), 32'd0);
    check("t5_rst_valid", 32'(rx_if.rx_valid), 32'd0);
    send_bit(1'b1);
    check("t5_idle_sample", 32'(rx_if.rx_valid), 32'd0);
    step();
    check("t5_no_pulse", 32'({rx_if.rx_valid, rx_if.frame_error, rx_if.parity_error}), 32'd0);

`ifdef UART_RX_ERR_CNT_EN
    // 6: saturating counters (CNT_W=2)
    err_cnt_clr = 1'b1;
    step();
    err_cnt_clr = 1'b0;
    check("t6_clr_start", 32'(err_cnt_start), 32'd0);
    check("t6_clr_parity", 32'(err_cnt_parity), 32'd0);
    check("t6_clr_frame", 32'(err_cnt_frame), 32'd0);
    check("t6_clr_break", 32'(err_cnt_break), 32'd0);
    set_cfg(4'd7, 1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 5; n++) begin
      exp_q.push_back(8'h35);
      send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      expect_frame("t6_perr", 1'b1, 1'b0, 1'b0);
    end
    check("t6_sat_parity", 32'(err_cnt_parity), 32'd3);
    check("t6_frame_zero", 32'(err_cnt_frame), 32'd0);
    exp_q.push_back(8'h35);
    send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("t6_perr_now", 32'(rx_if.parity_error), 32'd1);
    err_cnt_clr = 1'b1;
    step();
    err_cnt_clr = 1'b0;
    check("t6_clr_vs_inc", 32'(err_cnt_parity), 32'd0);
    step();
    check("t6_clr_hold", 32'(err_cnt_parity), 32'd0);
`endif

    step();
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
